// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
// Streams the SHA-256 message schedule W[t] together with the round constant
// K[t] for t = 0..ROUNDS-1. A padded 512-bit block is loaded into a 16-word
// sliding window. Each accepted output handshake shifts the window by one
// word and appends the next expanded word, so only 16 words of storage are
// needed instead of the full 64-word schedule.
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [31:0]  k_out,
    output logic [5:0]   round_idx,
    output logic         w_last,
    output logic         busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t      state;
    state_t      state_next;
    logic [31:0] win [16];
    logic [5:0]  round;
    logic        accept;
    logic        advance;
    logic        final_hs;
    logic [31:0] w_new;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // win[0] always holds W[t], so W[t+16] is built from window slots 14, 9, 1 and 0
    assign w_new    = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
    assign accept   = (state == IDLE) && blk_valid;
    assign advance  = (state == RUN) && w_ready;
    assign final_hs = advance && (round == LAST_ROUND);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: take one block in IDLE, leave RUN after the last round is consumed
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)   state_next = RUN;
            RUN:  if (final_hs) state_next = IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on w_ready
    always_comb begin
        blk_ready = (state == IDLE);
        w_valid   = (state == RUN);
        busy      = (state == RUN);
        w_out     = (state == RUN) ? win[0] : 32'h0;
        k_out     = K_ROM[round];
        round_idx = round;
        w_last    = (state == RUN) && (round == LAST_ROUND);
    end

    // Window load on block acceptance, shift-and-expand on every output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'h0;
            end
            round <= 6'd0;
        end else if (accept) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= blk_data[511 - 32*i -: 32];
            end
            round <= 6'd0;
        end else if (advance) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= w_new;
            round   <= final_hs ? 6'd0 : round + 6'd1;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule
// Scoreboard bench: each block acceptance pushes the expected (W, K, t, last)
// sequence from an array-based schedule model; independent monitors compare
// every cycle the DUT presents w_valid against the head of the queue.
`timescale 1ns/1ps
module tb_sha256_msg_schedule;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] k;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    localparam logic [31:0] KTAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_valid20;
    logic [511:0] blk_data;
    logic         w_ready;
    logic         blk_ready, w_valid, w_last, busy;
    logic [31:0]  w_out, k_out;
    logic [5:0]   round_idx;
    logic         blk_ready20, w_valid20, w_last20, busy20;
    logic [31:0]  w_out20, k_out20;
    logic [5:0]   round_idx20;

    exp_t         q64[$];
    exp_t         q20[$];
    exp_t         e64, e20;
    int           checkCount = 0;
    int           passCount = 0;
    int           cycle = 0;
    int           acc64Count = 0, acc20Count = 0;
    int           acc64Cycle = 0, lastHs64Cycle = 0;
    int           hs64Count = 0, hs20Count = 0;
    int           last64Count = 0;
    int           lastIdx20 = -1;
    bit           stallMode = 1'b0;
    logic [31:0]  capW [64];
    logic [31:0]  capK [64];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    sha256_msg_schedule #(.ROUNDS(64)) dut (
        .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .w_valid(w_valid), .w_ready(w_ready), .w_out(w_out),
        .k_out(k_out), .round_idx(round_idx), .w_last(w_last), .busy(busy)
    );

    sha256_msg_schedule #(.ROUNDS(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid20), .blk_ready(blk_ready20),
        .blk_data(blk_data), .w_valid(w_valid20), .w_ready(w_ready), .w_out(w_out20),
        .k_out(k_out20), .round_idx(round_idx20), .w_last(w_last20), .busy(busy20)
    );

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [511:0] makeBlock(input logic [31:0] seed);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) begin
            b[511 - 32*i -: 32] = seed ^ (32'h01010101 * i) ^ {i[7:0], 24'h5a3c00};
        end
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name, input string what);
        checkCount++;
        $display("[TB] FAIL %s: got %s, expected completion (t=%0t)", name, what, $time);
    endtask

    // Textbook 64-entry array form of the schedule, pushed as the expected stream
    task automatic pushExpected(input logic [511:0] blk, input int nr, input bit to20);
        logic [31:0] wm [64];
        exp_t e;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) wm[t] = blk[511 - 32*t -: 32];
            else        wm[t] = ssig1(wm[t-2]) + wm[t-7] + ssig0(wm[t-15]) + wm[t-16];
        end
        for (int t = 0; t < nr; t++) begin
            e.w = wm[t];
            e.k = KTAB[t];
            e.idx = 6'(t);
            e.last = (t == nr - 1);
            if (to20) q20.push_back(e);
            else      q64.push_back(e);
        end
    endtask

    // Block acceptance on the 64-round DUT issues a new expected stream
    always @(negedge clk) begin
        if (rst_n && blk_valid && blk_ready) begin
            acc64Cycle = cycle + 1;
            acc64Count++;
            pushExpected(blk_data, 64, 1'b0);
        end
        if (rst_n && blk_valid20 && blk_ready20) begin
            acc20Count++;
            pushExpected(blk_data, 20, 1'b1);
        end
    end

    // Monitor for the 64-round DUT: every valid cycle, stalled or not, must match the queue head
    always @(negedge clk) begin
        if (rst_n && w_valid) begin
            if (q64.size() == 0) begin
                failNow("unexpected_w_valid", "output with empty scoreboard");
            end else begin
                e64 = q64[0];
                checkOutput("w_out", w_out, e64.w);
                checkOutput("k_out", k_out, e64.k);
                checkOutput("round_idx", {26'h0, round_idx}, {26'h0, e64.idx});
                checkOutput("w_last", {31'h0, w_last}, {31'h0, e64.last});
                checkOutput("blk_ready_in_run", {31'h0, blk_ready}, 32'h0);
                if (w_ready) begin
                    void'(q64.pop_front());
                    hs64Count++;
                    capW[round_idx] = w_out;
                    capK[round_idx] = k_out;
                    if (w_last) begin
                        last64Count++;
                        lastHs64Cycle = cycle + 1;
                    end
                end
            end
        end
    end

    // Monitor for the reduced-round DUT
    always @(negedge clk) begin
        if (rst_n && w_valid20) begin
            if (q20.size() == 0) begin
                failNow("unexpected_w_valid20", "output with empty scoreboard");
            end else begin
                e20 = q20[0];
                checkOutput("w_out20", w_out20, e20.w);
                checkOutput("k_out20", k_out20, e20.k);
                checkOutput("round_idx20", {26'h0, round_idx20}, {26'h0, e20.idx});
                checkOutput("w_last20", {31'h0, w_last20}, {31'h0, e20.last});
                if (w_ready) begin
                    void'(q20.pop_front());
                    hs20Count++;
                    if (w_last20) lastIdx20 = int'(round_idx20);
                end
            end
        end
    end

    // Consumer readiness: always ready, or roughly 50% random stalls
    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            w_ready = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Poll until the selected DUT has drained its stream and dropped w_valid
    task automatic waitIdle(input bit to20, input int maxCycles);
        bit done = 1'b0;
        for (int c = 0; c < maxCycles && !done; c++) begin
            @(posedge clk);
            #1;
            if (to20) done = (q20.size() == 0) && !w_valid20;
            else      done = (q64.size() == 0) && !w_valid;
        end
        if (!done) begin
            failNow(to20 ? "drain_timeout20" : "drain_timeout", "timeout");
            q64.delete();
            q20.delete();
        end
    endtask

    // Offer one block, drop blk_valid right after it is taken, then drain the stream
    task automatic applyStimulus(input logic [511:0] blk, input bit stall, input bit to20);
        int startCount;
        bit taken = 1'b0;
        startCount = to20 ? acc20Count : acc64Count;
        stallMode = stall;
        @(posedge clk);
        #1;
        blk_data = blk;
        if (to20) blk_valid20 = 1'b1;
        else      blk_valid = 1'b1;
        for (int c = 0; c < 50 && !taken; c++) begin
            @(posedge clk);
            #1;
            taken = (to20 ? acc20Count : acc64Count) != startCount;
        end
        blk_valid = 1'b0;
        blk_valid20 = 1'b0;
        if (!taken) failNow("accept_timeout", "timeout");
        waitIdle(to20, 1000);
        stallMode = 1'b0;
    endtask

    initial begin
        int a0;
        int waited;
        bit seen;
        rst_n = 1'b0;
        blk_valid = 1'b1;
        blk_valid20 = 1'b0;
        blk_data = ABC_BLK;

        // Reset held with a block offered: reset outputs, nothing loaded
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_blk_ready", {31'h0, blk_ready}, 32'h1);
        checkOutput("rst_w_valid", {31'h0, w_valid}, 32'h0);
        checkOutput("rst_w_out", w_out, 32'h0);
        checkOutput("rst_k_out", k_out, 32'h428a2f98);
        checkOutput("rst_round_idx", {26'h0, round_idx}, 32'h0);
        checkOutput("rst_w_last", {31'h0, w_last}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_no_accept", acc64Count, 32'h0);

        // Release reset: the abc block is taken on the first edge, first W one cycle later
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waited = 0;
        while (acc64Count == 0 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        blk_valid = 1'b0;
        checkOutput("accept_first_edge", waited, 32'd1);
        @(negedge clk);
        checkOutput("first_valid_latency", {31'h0, w_valid}, 32'h1);
        waitIdle(1'b0, 1000);
        checkOutput("abc_handshakes", hs64Count, 32'd64);
        checkOutput("abc_w0", capW[0], 32'h61626380);
        checkOutput("abc_w15", capW[15], 32'h00000018);
        checkOutput("abc_w16", capW[16], 32'h61626380);
        checkOutput("abc_w17", capW[17], 32'h000F0000);
        checkOutput("abc_k63", capK[63], 32'hc67178f2);
        checkOutput("abc_last_count", last64Count, 32'd1);
        checkOutput("idle_blk_ready", {31'h0, blk_ready}, 32'h1);
        checkOutput("idle_w_out", w_out, 32'h0);
        checkOutput("idle_busy", {31'h0, busy}, 32'h0);

        // Same block with random backpressure
        hs64Count = 0;
        last64Count = 0;
        applyStimulus(ABC_BLK, 1'b1, 1'b0);
        checkOutput("stall_handshakes", hs64Count, 32'd64);
        checkOutput("stall_last_count", last64Count, 32'd1);

        // Back-to-back blocks with blk_valid held high the whole time
        hs64Count = 0;
        a0 = acc64Count;
        @(posedge clk);
        #1;
        blk_data = makeBlock(32'hc0ffee11);
        blk_valid = 1'b1;
        waited = 0;
        while (acc64Count == a0 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        blk_data = ABC_BLK;
        waited = 0;
        while (acc64Count < a0 + 2 && waited < 400) begin
            @(posedge clk);
            #1;
            waited++;
        end
        blk_valid = 1'b0;
        checkOutput("b2b_accepts", acc64Count - a0, 32'd2);
        checkOutput("b2b_turnaround", acc64Cycle - lastHs64Cycle, 32'd1);
        waitIdle(1'b0, 1000);
        checkOutput("b2b_handshakes", hs64Count, 32'd128);

        // Reset in the middle of a block at round 30
        last64Count = 0;
        a0 = acc64Count;
        @(posedge clk);
        #1;
        blk_data = makeBlock(32'h13579bdf);
        blk_valid = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (acc64Count != a0) blk_valid = 1'b0;
            seen = w_valid && (round_idx == 6'd30);
        end
        blk_valid = 1'b0;
        if (!seen) failNow("round30_timeout", "timeout");
        rst_n = 1'b0;
        q64.delete();
        @(negedge clk);
        checkOutput("midrst_w_valid", {31'h0, w_valid}, 32'h0);
        checkOutput("midrst_blk_ready", {31'h0, blk_ready}, 32'h1);
        checkOutput("midrst_round_idx", {26'h0, round_idx}, 32'h0);
        checkOutput("midrst_w_out", w_out, 32'h0);
        checkOutput("midrst_k_out", k_out, 32'h428a2f98);
        checkOutput("midrst_no_last", last64Count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hs64Count = 0;
        applyStimulus(makeBlock(32'h2468ace0), 1'b1, 1'b0);
        checkOutput("post_rst_handshakes", hs64Count, 32'd64);

        // Reduced-round build
        applyStimulus(ABC_BLK, 1'b0, 1'b1);
        checkOutput("r20_handshakes", hs20Count, 32'd20);
        checkOutput("r20_last_idx", lastIdx20, 32'd19);
        checkOutput("r20_idle", {31'h0, blk_ready20}, 32'h1);
        checkOutput("r20_busy", {31'h0, busy20}, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
